tcb_arb: RTL and testbench
==========================

# tcb_arb

Two-manager to one-subordinate TCB arbiter that merges the instruction fetch bus and the load/store bus onto a single memory port for unified-memory SoC variants. It sits between `r5p_core` and a single-port memory or the `tcb_dec` load/store decoder. It grants one request per cycle and routes each read response back to the port that issued it after the fixed bus response delay.

## Interface
Parameters:
- `AW`, 32, address width in bits (byte address).
- `DW`, 32, data width in bits; `BW = DW/8` byte enables.
- `DLY`, 1, subordinate response delay in cycles; legal range 0..4.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `sub0_vld`/`sub1_vld`  in  1  manager N request valid; port 0 is fetch, port 1 is load/store.
- `sub0_wen`/`sub1_wen`  in  1  write enable.
- `sub0_adr`/`sub1_adr`  in  AW  address.
- `sub0_ben`/`sub1_ben`  in  BW  byte enables.
- `sub0_wdt`/`sub1_wdt`  in  DW  write data.
- `sub0_rdt`/`sub1_rdt`  out  DW  read data.
- `sub0_rdy`/`sub1_rdy`  out  1  request accepted.
- `man_vld`, `man_wen`, `man_adr`, `man_ben`, `man_wdt`  out  1/1/AW/BW/DW  merged request.
- `man_rdt`  in  DW  read data from the subordinate.
- `man_rdy`  in  1  subordinate ready.

## Operation
- Transfer rule on any TCB link: a transfer occurs in a cycle where `vld && rdy`. Read data for that transfer is valid on `rdt` exactly `DLY` cycles later.
- Grant `gnt` (0/1) is combinational from the current requests:
  - Only one `subN_vld` high: `gnt = N`.
  - Both high: `gnt = pri`.
  - Neither high: `gnt` is don't-care.
- Request path: `man_vld = sub0_vld | sub1_vld`. `man_wen/adr/ben/wdt` are muxed from port `gnt`.
- Ready path: `subN_rdy = man_rdy && gnt == N && subN_vld`. The losing port sees `rdy=0` and must hold its request stable.
- Priority register `pri`: after a transfer by port N, `pri <= ~N`. It is unchanged in cycles with no transfer. Reset value is 0.
- Response routing: a shift register of depth `DLY` holds `{act, id}` per stage. A transfer pushes `{1, gnt}` and a no-transfer cycle pushes `{0, x}`. The tail stage determines routing.
  - `subN_rdt = man_rdt` when the tail is `act` with `id == N`; otherwise `subN_rdt = '0`.
  - With `DLY == 0` the pipeline is absent and routing uses the current `gnt` and transfer.
- Writes also occupy a pipeline slot (`act=1`). The returned `rdt` is forwarded and the manager ignores it.
- Reset: `pri=0`, all pipeline stages `act=0`, so both `subN_rdt = 0`. Outputs during reset follow the combinational rules; managers must hold `vld` low while `rst` is high.
- Reset mid-operation: in-flight responses are discarded, and no `rdt` is routed in the `DLY` cycles after reset deassertion unless new transfers occur.
- `man_rdy` low: no transfer, `pri` holds, the pipeline pushes `act=0`, and both requests stay pending.

## Timing
- The request path is zero-latency combinational (`sub*` → `man_*`, `man_rdy` → `sub*_rdy`).
- The response is delayed by exactly `DLY` cycles; the pipeline adds no extra latency.
- Throughput is one transfer per cycle. Under continuous contention the ports alternate 0,1,0,1… starting with port 0 after reset.
- No combinational path from `man_rdt` to any request output.

## Configuration
- Macro: `TCB_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin priority via `pri` as described above.
- Undefined: fixed priority, where port 1 (load/store) always wins contention. The `pri` register is not implemented and `gnt = sub1_vld ? 1 : 0`.

## Test plan
- Single fetch, `DLY=1`: `sub0_vld=1`, `adr=0x40`, `man_rdy=1`, `man_rdt=0xDEADBEEF` next cycle → `sub0_rdy=1` in cycle 0; `sub0_rdt=0xDEADBEEF` and `sub1_rdt=0` in cycle 1.
- Contention, round-robin: both `vld` high for 4 cycles with distinct addresses 0x100/0x200 → `man_adr` = 0x100, 0x200, 0x100, 0x200; each `rdt` is returned to the issuing port one cycle later.
- Contention, fixed priority (macro undefined): both `vld` high for 3 cycles → port 1 granted every cycle; `sub0_rdy=0` throughout.
- Backpressure: both `vld` high, `man_rdy=0` for 2 cycles then 1 → no `rdy` for 2 cycles; then port `pri` (0 after reset) is granted and `pri` does not advance during the stall.
- `DLY=3` interleave: transfers 0,1,1 on consecutive cycles → responses route to sub0, sub1, sub1 on cycles 3,4,5; each `rdt` is zero when not routed.
- Reset mid-flight: issue a port-1 read at `DLY=2`, assert `rst` the next cycle → `sub1_rdt=0` two cycles later; `pri=0` after reset.

Source files
------------

// File: rtl/tcb_arb_if.sv
// tcb_arb_if
// Single TCB link (request channel plus read-data return) used on every port
// of the arbiter.
//   master modport : drives vld/wen/adr/ben/wdt, receives rdt/rdy
//   slave modport  : receives vld/wen/adr/ben/wdt, drives rdt/rdy
// Parameters: AW address width, DW data width (BW = DW/8 byte enables).
interface tcb_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  logic          vld;
  logic          wen;
  logic [AW-1:0] adr;
  logic [BW-1:0] ben;
  logic [DW-1:0] wdt;
  logic [DW-1:0] rdt;
  logic          rdy;

  modport master (
    output vld, wen, adr, ben, wdt,
    input  rdt, rdy
  );

  modport slave (
    input  vld, wen, adr, ben, wdt,
    output rdt, rdy
  );
endinterface

// File: rtl/tcb_arb.sv
// tcb_arb
// Merges the instruction-fetch link (sub0) and the load/store link (sub1)
// onto one subordinate link (man). One request is granted per cycle; the
// grant id travels down a DLY-deep pipeline so each read response is routed
// back to the port that issued it.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   sub0  slave link from the fetch manager
//   sub1  slave link from the load/store manager
//   man   master link to the shared subordinate
// Parameters: AW, DW, DLY (subordinate response delay, 0..4).
// Build option: define TCB_ARB_ROUND_ROBIN_EN for alternating priority under
// contention; otherwise port 1 (load/store) always wins.
module tcb_arb #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int DLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  tcb_arb_if.slave   sub0,
  tcb_arb_if.slave   sub1,
  tcb_arb_if.master  man
);

  logic gnt;
  logic xfr;
  logic rsp_vld;
  logic rsp_id;

`ifdef TCB_ARB_ROUND_ROBIN_EN
  // pri points at the port that wins the next contended cycle; it only
  // moves on an actual transfer so a stalled subordinate keeps the order.
  logic pri;

  always_ff @(posedge clk) begin
    if (rst) begin
      pri <= 1'b0;
    end else if (xfr) begin
      pri <= ~gnt;
    end
  end

  always_comb begin
    gnt = sub1.vld;
    if (sub0.vld && sub1.vld) begin
      gnt = pri;
    end
  end
`else
  always_comb begin
    gnt = sub1.vld;
  end
`endif

  // Request stage (combinational)
  assign man.vld = sub0.vld | sub1.vld;
  assign xfr     = man.vld & man.rdy;

  always_comb begin
    man.wen = sub0.wen;
    man.adr = sub0.adr;
    man.ben = sub0.ben;
    man.wdt = sub0.wdt;
    if (gnt) begin
      man.wen = sub1.wen;
      man.adr = sub1.adr;
      man.ben = sub1.ben;
      man.wdt = sub1.wdt;
    end
  end

  assign sub0.rdy = man.rdy & ~gnt & sub0.vld;
  assign sub1.rdy = man.rdy &  gnt & sub1.vld;

  // Response pipeline: vld_p is control (reset), id_p is data (not reset)
  generate
    if (DLY == 0) begin : g_nodly
      assign rsp_vld = xfr;
      assign rsp_id  = gnt;
    end else begin : g_dly
      logic [DLY-1:0] vld_p;
      logic [DLY-1:0] id_p;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= xfr;
          for (int i = 1; i < DLY; i++) begin
            vld_p[i] <= vld_p[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        id_p[0] <= gnt;
        for (int i = 1; i < DLY; i++) begin
          id_p[i] <= id_p[i-1];
        end
      end

      assign rsp_vld = vld_p[DLY-1];
      assign rsp_id  = id_p[DLY-1];
    end
  endgenerate

  // Response routing stage
  assign sub0.rdt = (rsp_vld && !rsp_id) ? man.rdt : '0;
  assign sub1.rdt = (rsp_vld &&  rsp_id) ? man.rdt : '0;

endmodule

// File: tb/tb_tcb_arb.sv
// tb_tcb_arb
// Directed bench for tcb_arb. Four arbiters with DLY = 0..3 share one set of
// request/response stimulus, so every step is checked against each delay.
module tb_tcb_arb;

`ifdef TCB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, w0, w1, mrdy;
  logic [31:0] a0, a1, d0, d1, mrdt;
  logic [3:0]  b0, b1;

  logic        o_s0_rdy [4];
  logic        o_s1_rdy [4];
  logic        o_man_vld[4];
  logic        o_man_wen[4];
  logic [31:0] o_man_adr[4];
  logic [31:0] o_man_wdt[4];
  logic [3:0]  o_man_ben[4];
  logic [31:0] o_s0_rdt [4];
  logic [31:0] o_s1_rdt [4];

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    tcb_arb_if #(.AW(32), .DW(32)) s0_if (), s1_if (), m_if ();

    assign s0_if.vld = v0;
    assign s0_if.wen = w0;
    assign s0_if.adr = a0;
    assign s0_if.ben = b0;
    assign s0_if.wdt = d0;
    assign s1_if.vld = v1;
    assign s1_if.wen = w1;
    assign s1_if.adr = a1;
    assign s1_if.ben = b1;
    assign s1_if.wdt = d1;
    assign m_if.rdy  = mrdy;
    assign m_if.rdt  = mrdt;

    assign o_s0_rdy[k]  = s0_if.rdy;
    assign o_s1_rdy[k]  = s1_if.rdy;
    assign o_s0_rdt[k]  = s0_if.rdt;
    assign o_s1_rdt[k]  = s1_if.rdt;
    assign o_man_vld[k] = m_if.vld;
    assign o_man_wen[k] = m_if.wen;
    assign o_man_adr[k] = m_if.adr;
    assign o_man_wdt[k] = m_if.wdt;
    assign o_man_ben[k] = m_if.ben;

    tcb_arb #(.AW(32), .DW(32), .DLY(k)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .sub0 (s0_if.slave),
      .sub1 (s1_if.slave),
      .man  (m_if.master)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g, gp;
    int t;
    int tid[3];
    logic [31:0] e0, e1;

    tid = '{0, 1, 1};
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    b0 = 4'hF; b1 = 4'h3;
    mrdy = 1'b1;
    mrdt = 32'h1234_5678;

    // Reset state
    repeat (3) cyc();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_s0_rdt_d%0d", k), o_s0_rdt[k], 32'h0);
      chk($sformatf("rst_s1_rdt_d%0d", k), o_s1_rdt[k], 32'h0);
      chk($sformatf("rst_man_vld_d%0d", k), {31'b0, o_man_vld[k]}, 32'h0);
      chk($sformatf("rst_s0_rdy_d%0d", k), {31'b0, o_s0_rdy[k]}, 32'h0);
      chk($sformatf("rst_s1_rdy_d%0d", k), {31'b0, o_s1_rdy[k]}, 32'h0);
    end
    cyc();
    rst = 1'b0;
    cyc();

    // Contention, 4 cycles
    a0 = 32'h100; a1 = 32'h200; w0 = 1'b0; w1 = 1'b1;
    d0 = 32'h1111_1111; d1 = 32'h2222_2222;
    v0 = 1'b1; v1 = 1'b1; mrdy = 1'b1;
    gp = 0;
    for (int i = 0; i < 4; i++) begin
      mrdt = 32'hA0 + i;
      g = RR ? (i % 2) : 1;
      #1;
      chk($sformatf("cont%0d_adr", i), o_man_adr[1], g ? 32'h200 : 32'h100);
      chk($sformatf("cont%0d_adr_d3", i), o_man_adr[3], g ? 32'h200 : 32'h100);
      chk($sformatf("cont%0d_s0_rdy", i), {31'b0, o_s0_rdy[1]}, g ? 32'h0 : 32'h1);
      chk($sformatf("cont%0d_s1_rdy", i), {31'b0, o_s1_rdy[1]}, g ? 32'h1 : 32'h0);
      chk($sformatf("cont%0d_wen", i), {31'b0, o_man_wen[1]}, g ? 32'h1 : 32'h0);
      chk($sformatf("cont%0d_wdt", i), o_man_wdt[1], g ? 32'h2222_2222 : 32'h1111_1111);
      chk($sformatf("cont%0d_ben", i), {28'b0, o_man_ben[1]}, g ? 32'h3 : 32'hF);
      chk($sformatf("cont%0d_s0_rdt_d0", i), o_s0_rdt[0], (g == 0) ? mrdt : 32'h0);
      chk($sformatf("cont%0d_s1_rdt_d0", i), o_s1_rdt[0], (g == 1) ? mrdt : 32'h0);
      if (i > 0) begin
        chk($sformatf("cont%0d_s0_rdt_d1", i), o_s0_rdt[1], (gp == 0) ? mrdt : 32'h0);
        chk($sformatf("cont%0d_s1_rdt_d1", i), o_s1_rdt[1], (gp == 1) ? mrdt : 32'h0);
      end
      gp = g;
      cyc();
    end
    v0 = 1'b0; v1 = 1'b0; w1 = 1'b0;
    mrdt = 32'hA4;
    #1;
    chk("cont_tail_s0_rdt_d1", o_s0_rdt[1], (gp == 0) ? mrdt : 32'h0);
    chk("cont_tail_s1_rdt_d1", o_s1_rdt[1], (gp == 1) ? mrdt : 32'h0);
    chk("cont_tail_s0_rdt_d0", o_s0_rdt[0], 32'h0);
    chk("cont_tail_s1_rdt_d0", o_s1_rdt[0], 32'h0);
    repeat (4) cyc();

    // Single fetch
    mrdt = 32'hDEAD_BEEF;
    v0 = 1'b1; a0 = 32'h40; w0 = 1'b0;
    #1;
    chk("fetch_s0_rdy", {31'b0, o_s0_rdy[1]}, 32'h1);
    chk("fetch_s1_rdy", {31'b0, o_s1_rdy[1]}, 32'h0);
    chk("fetch_man_vld", {31'b0, o_man_vld[1]}, 32'h1);
    chk("fetch_man_adr", o_man_adr[1], 32'h40);
    chk("fetch_s0_rdt_d0", o_s0_rdt[0], 32'hDEAD_BEEF);
    cyc();
    v0 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      for (int k = 1; k <= 3; k++) begin
        chk($sformatf("fetch_c%0d_s0_rdt_d%0d", c, k), o_s0_rdt[k],
            (k == c) ? 32'hDEAD_BEEF : 32'h0);
        chk($sformatf("fetch_c%0d_s1_rdt_d%0d", c, k), o_s1_rdt[k], 32'h0);
      end
      cyc();
    end

    // Backpressure after reset (pri was left at 1 by the fetch in RR mode)
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    v0 = 1'b1; v1 = 1'b1; a0 = 32'h100; a1 = 32'h200;
    mrdy = 1'b0; mrdt = 32'h55;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("bp%0d_s0_rdy", s), {31'b0, o_s0_rdy[1]}, 32'h0);
      chk($sformatf("bp%0d_s1_rdy", s), {31'b0, o_s1_rdy[1]}, 32'h0);
      chk($sformatf("bp%0d_man_vld", s), {31'b0, o_man_vld[1]}, 32'h1);
      chk($sformatf("bp%0d_s0_rdt_d1", s), o_s0_rdt[1], 32'h0);
      chk($sformatf("bp%0d_s1_rdt_d1", s), o_s1_rdt[1], 32'h0);
      cyc();
    end
    mrdy = 1'b1;
    g = RR ? 0 : 1;
    #1;
    chk("bp_rel_s0_rdy", {31'b0, o_s0_rdy[1]}, g ? 32'h0 : 32'h1);
    chk("bp_rel_s1_rdy", {31'b0, o_s1_rdy[1]}, g ? 32'h1 : 32'h0);
    chk("bp_rel_adr", o_man_adr[1], g ? 32'h200 : 32'h100);
    cyc();
    #1;
    chk("bp_next_s1_rdy", {31'b0, o_s1_rdy[1]}, 32'h1);
    chk("bp_next_adr", o_man_adr[1], 32'h200);
    chk("bp_next_s0_rdt_d1", o_s0_rdt[1], (g == 0) ? 32'h55 : 32'h0);
    chk("bp_next_s1_rdt_d1", o_s1_rdt[1], (g == 1) ? 32'h55 : 32'h0);
    cyc();
    v0 = 1'b0; v1 = 1'b0;
    repeat (4) cyc();

    // Interleave: transfers by ports 0,1,1 on consecutive cycles
    for (int c = 0; c < 7; c++) begin
      v0 = (c == 0);
      v1 = (c == 1 || c == 2);
      mrdt = 32'hC0 + c;
      #1;
      for (int k = 0; k < 4; k++) begin
        t = c - k;
        e0 = (t >= 0 && t <= 2 && tid[t] == 0) ? mrdt : 32'h0;
        e1 = (t >= 0 && t <= 2 && tid[t] == 1) ? mrdt : 32'h0;
        chk($sformatf("ilv_c%0d_s0_rdt_d%0d", c, k), o_s0_rdt[k], e0);
        chk($sformatf("ilv_c%0d_s1_rdt_d%0d", c, k), o_s1_rdt[k], e1);
      end
      cyc();
    end

    // Reset mid-flight: port-1 read, reset the following cycle
    a1 = 32'h300; w1 = 1'b0; v1 = 1'b1; mrdt = 32'h77;
    cyc();
    v1 = 1'b0; rst = 1'b1;
    #1;
    chk("rmf_s1_rdt_d1", o_s1_rdt[1], 32'h77);
    cyc();
    rst = 1'b0;
    #1;
    chk("rmf_s1_rdt_d2", o_s1_rdt[2], 32'h0);
    chk("rmf_s0_rdt_d2", o_s0_rdt[2], 32'h0);
    cyc();
    #1;
    chk("rmf_s1_rdt_d3", o_s1_rdt[3], 32'h0);
    cyc();

    // Priority returns to port 0 after reset
    v0 = 1'b1;
    cyc();
    v0 = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    v0 = 1'b1; v1 = 1'b1;
    g = RR ? 0 : 1;
    #1;
    chk("prst_s0_rdy", {31'b0, o_s0_rdy[1]}, g ? 32'h0 : 32'h1);
    chk("prst_s1_rdy", {31'b0, o_s1_rdy[1]}, g ? 32'h1 : 32'h0);
    cyc();
    v0 = 1'b0; v1 = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
